// File: rtl/gate_selftest_pkg.sv
// rtl/gate_selftest_pkg.sv - shared FSM states, err_mask bit indices and vector count
package gate_selftest_pkg;

   localparam int NUM_VECTORS = 4;
   localparam int NUM_GATES   = 7;
   localparam int VIDX_W      = 2;
   localparam int CNT_W       = 3;

   localparam int ERR_AND  = 0;
   localparam int ERR_OR   = 1;
   localparam int ERR_NOT  = 2;
   localparam int ERR_XOR  = 3;
   localparam int ERR_XNOR = 4;
   localparam int ERR_NOR  = 5;
   localparam int ERR_NAND = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/gate_selftest_expect.sv
// rtl/gate_selftest_expect.sv - reference truth values of the seven gates for one operand pair
module gate_expect
   import gate_selftest_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   output logic [NUM_GATES-1:0] exp_bits
);

   always_comb begin
      exp_bits           = '0;
      exp_bits[ERR_AND]  = a & b;
      exp_bits[ERR_OR]   = a | b;
      exp_bits[ERR_NOT]  = ~a;
      exp_bits[ERR_XOR]  = a ^ b;
      exp_bits[ERR_XNOR] = ~(a ^ b);
      exp_bits[ERR_NOR]  = ~(a | b);
      exp_bits[ERR_NAND] = ~(a & b);
   end

endmodule

// File: rtl/gate_selftest.sv
// rtl/gate_selftest.sv - walks the four operand pairs through an external gate block and logs miscompares
module gate_selftest
   import gate_selftest_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 a_o,
   output logic                 b_o,
   input  logic                 and_i,
   input  logic                 or_i,
   input  logic                 not_i,
   input  logic                 xor_i,
   input  logic                 xnor_i,
   input  logic                 nor_i,
   input  logic                 nand_i,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [NUM_GATES-1:0] err_mask,
   output logic [CNT_W-1:0]     err_count
);

   state_t                 state;
   state_t                 state_nxt;
   logic [VIDX_W-1:0]      vec_idx;
   logic [3:0]             settle_cnt;
   logic [NUM_GATES-1:0]   exp_bits;
   logic [NUM_GATES-1:0]   obs_bits;
   logic [NUM_GATES-1:0]   miss;
   logic                   settle_last;
   logic                   vec_last;

   // Expected values come from the registered operands, so they are stable for the whole vector.
   gate_expect u_expect (
      .a        (a_o),
      .b        (b_o),
      .exp_bits (exp_bits)
   );

   always_comb begin
      obs_bits           = '0;
      obs_bits[ERR_AND]  = and_i;
      obs_bits[ERR_OR]   = or_i;
      obs_bits[ERR_NOT]  = not_i;
      obs_bits[ERR_XOR]  = xor_i;
      obs_bits[ERR_XNOR] = xnor_i;
      obs_bits[ERR_NOR]  = nor_i;
      obs_bits[ERR_NAND] = nand_i;
   end

   assign miss        = obs_bits ^ exp_bits;
   assign settle_last = (settle_cnt == 4'(SETTLE_CYC - 1));
   assign vec_last    = (vec_idx == VIDX_W'(NUM_VECTORS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_APPLY;
         ST_APPLY: if (settle_last) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = vec_last ? ST_DONE : ST_APPLY;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // busy/done are loaded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx    <= '0;
         settle_cnt <= '0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_mask   <= '0;
         err_count  <= '0;
      end else begin
         busy <= (state_nxt != ST_IDLE);
         done <= (state_nxt == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  vec_idx    <= '0;
                  settle_cnt <= '0;
                  a_o        <= 1'b0;
                  b_o        <= 1'b0;
                  pass       <= 1'b0;
                  err_mask   <= '0;
                  err_count  <= '0;
               end
            end
            ST_APPLY: begin
               settle_cnt <= settle_last ? 4'd0 : settle_cnt + 4'd1;
            end
            ST_CHECK: begin
               err_mask <= err_mask | miss;
               if (|miss) begin
                  err_count <= err_count + CNT_W'(1);
               end
               // pass must already reflect this final vector when done is raised.
               if (vec_last) begin
                  pass <= ((err_mask | miss) == '0);
               end else begin
                  vec_idx      <= vec_idx + VIDX_W'(1);
                  {a_o, b_o}   <= vec_idx + VIDX_W'(1);
               end
               settle_cnt <= '0;
            end
            ST_DONE: begin
               a_o <= 1'b0;
               b_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_selftest.sv
// tb/tb_gate_selftest.sv - scoreboard bench for gate_selftest with faulty and correct gate models
module tb_gate_selftest;
   import gate_selftest_pkg::*;

   typedef struct {
      logic [6:0] mask;
      logic [2:0] cnt;
      logic       pass;
      int         start_cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // fault 0: correct, 1: or_i = a&b, 2: not_i stuck at 0
   function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
      logic [6:0] g;
      g[0] = a & b;
      g[1] = a | b;
      g[2] = ~a;
      g[3] = a ^ b;
      g[4] = ~(a ^ b);
      g[5] = ~(a | b);
      g[6] = ~(a & b);
      if (fault == 1) g[1] = a & b;
      if (fault == 2) g[2] = 1'b0;
      return g;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   logic       start0 = 1'b0, start1 = 1'b0;
   int         fault0 = 0, fault1 = 0;
   logic       a0, b0, a1, b1;
   logic [6:0] g0, g1;
   logic       busy0, done0, pass0, busy1, done1, pass1;
   logic [6:0] mask0, mask1;
   logic [2:0] cnt0, cnt1;
   exp_t       q0[$];
   exp_t       q1[$];
   exp_t       m0, m1;

   assign g0 = gate_model(a0, b0, fault0);
   assign g1 = gate_model(a1, b1, fault1);

   gate_selftest dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a0), .b_o(b0),
      .and_i(g0[0]), .or_i(g0[1]), .not_i(g0[2]), .xor_i(g0[3]),
      .xnor_i(g0[4]), .nor_i(g0[5]), .nand_i(g0[6]),
      .busy(busy0), .done(done0), .pass(pass0), .err_mask(mask0), .err_count(cnt0)
   );

   gate_selftest #(.SETTLE_CYC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_o(a1), .b_o(b1),
      .and_i(g1[0]), .or_i(g1[1]), .not_i(g1[2]), .xor_i(g1[3]),
      .xnor_i(g1[4]), .nor_i(g1[5]), .nand_i(g1[6]),
      .busy(busy1), .done(done1), .pass(pass1), .err_mask(mask1), .err_count(cnt1)
   );

   always @(negedge clk) begin
      if (rst_n && done0) begin
         chk("d0_done_expected", q0.size() > 0, 1);
         if (q0.size() > 0) begin
            m0 = q0.pop_front();
            chk("d0_err_mask", mask0, m0.mask);
            chk("d0_err_count", cnt0, m0.cnt);
            chk("d0_pass", pass0, m0.pass);
            chk("d0_latency", cyc - m0.start_cyc, 13);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done1) begin
         chk("d1_done_expected", q1.size() > 0, 1);
         if (q1.size() > 0) begin
            m1 = q1.pop_front();
            chk("d1_err_mask", mask1, m1.mask);
            chk("d1_err_count", cnt1, m1.cnt);
            chk("d1_pass", pass1, m1.pass);
            chk("d1_latency", cyc - m1.start_cyc, 9);
         end
      end
   end

   task automatic run0(input int fault, input logic [6:0] m, input logic [2:0] c,
                       input logic p, input bit hold);
      exp_t e;
      int   n;
      @(negedge clk);
      fault0 = fault;
      e.mask = m; e.cnt = c; e.pass = p; e.start_cyc = cyc;
      q0.push_back(e);
      start0 = 1'b1;
      @(negedge clk);
      if (!hold) start0 = 1'b0;
      n = 0;
      while (!done0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("d0_done_seen", done0, 1);
      start0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("d0_hold_mask", mask0, m);
      chk("d0_hold_count", cnt0, c);
      chk("d0_hold_pass", pass0, p);
      chk("d0_idle_busy", busy0, 0);
      chk("d0_idle_ab", {a0, b0}, 0);
   endtask

   task automatic run1(input int fault, input logic [6:0] m, input logic [2:0] c, input logic p);
      exp_t e;
      int   n;
      @(negedge clk);
      fault1 = fault;
      e.mask = m; e.cnt = c; e.pass = p; e.start_cyc = cyc;
      q1.push_back(e);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("d1_done_seen", done1, 1);
   endtask

   initial begin
      int n;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ab", {a0, b0}, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_mask", mask0, 0);
      chk("rst_count", cnt0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run0(0, 7'b0000000, 3'd0, 1'b1, 1'b0);
      run0(1, 7'b0000010, 3'd2, 1'b0, 1'b0);
      run0(2, 7'b0000100, 3'd2, 1'b0, 1'b0);
      run0(0, 7'b0000000, 3'd0, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("hold_no_restart_busy", busy0, 0);

      // Abort during the vector-10 settle phase.
      run0(1, 7'b0000010, 3'd2, 1'b0, 1'b0);
      begin
         exp_t e;
         @(negedge clk);
         fault0 = 0;
         e.mask = 7'b0; e.cnt = 3'd0; e.pass = 1'b1; e.start_cyc = cyc;
         q0.push_back(e);
         start0 = 1'b1;
         @(negedge clk);
         start0 = 1'b0;
         n = 0;
         while (!(a0 == 1'b1 && b0 == 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("abort_reached_vec10", {a0, b0}, 2'b10);
         rst_n = 1'b0;
         void'(q0.pop_back());
         #1;
         chk("abort_ab", {a0, b0}, 0);
         chk("abort_busy", busy0, 0);
         chk("abort_done", done0, 0);
         chk("abort_pass", pass0, 0);
         chk("abort_mask", mask0, 0);
         chk("abort_count", cnt0, 0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         n = 0;
         repeat (20) begin
            @(negedge clk);
            if (done0) n++;
         end
         chk("abort_no_done", n, 0);
      end
      run0(0, 7'b0000000, 3'd0, 1'b1, 1'b0);

      run1(1, 7'b0000010, 3'd2, 1'b0);
      run1(0, 7'b0000000, 3'd0, 1'b1);
      repeat (3) @(negedge clk);
      chk("d1_final_pass", pass1, 1);
      chk("d1_final_mask", mask1, 0);
      chk("d0_queue_drained", q0.size(), 0);
      chk("d1_queue_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gate_selftest.md
GATE_SELFTEST -- requirements
Module: gate_selftest

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, giving the number of cycles each input vector is held before its outputs are sampled (legal range 1..15).
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-006 SHALL have ports a_o and b_o, output, 1 bit each: registered operands driven to the downstream two-input gate block.
REQ-007 SHALL have ports and_i, or_i, not_i, xor_i, xnor_i, nor_i and nand_i, input, 1 bit each: gate-block results.
REQ-008 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-010 SHALL have port pass, output, 1 bit: last run had zero mismatches.
REQ-011 SHALL have port err_mask, output, 7 bits: sticky per-gate mismatch flags, where [0]=and, [1]=or, [2]=not, [3]=xor, [4]=xnor, [5]=nor and [6]=nand.
REQ-012 SHALL have port err_count, output, 3 bits: number of vectors (0..4) with at least one mismatch.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, APPLY, CHECK and DONE.
REQ-014 SHALL, in IDLE with start=1, clear err_mask, err_count, pass and the vector index, then enter APPLY the next cycle; start=1 in any other state SHALL be ignored.
REQ-015 SHALL, in APPLY, drive {a_o,b_o} = vector index (00, 01, 10, 11 in order) and stay for exactly SETTLE_CYC cycles, counted by a settle counter.
REQ-016 SHALL, in CHECK (one cycle), compare each *_i against the expected values and OR each per-gate miscompare into err_mask; err_count SHALL increment by 1 if any bit miscompares on that vector.
REQ-017 SHALL use these expected values: and=a&b, or=a|b, not=~a, xor=a^b, xnor=~(a^b), nor=~(a|b), nand=~(a&b).
REQ-018 SHALL, when leaving CHECK, go to DONE if the vector index is 3, otherwise increment the index and return to APPLY; the index SHALL never wrap inside a run.
REQ-019 SHALL spend one cycle in DONE with done=1 and load pass=(err_mask==0 including the final CHECK update), then return to IDLE.
REQ-020 SHALL hold pass, err_mask and err_count stable from DONE until the next accepted start.
REQ-021 SHALL hold a_o and b_o at the last vector through DONE and drive them to 0 on the return to IDLE.
REQ-022 SHALL assert done exactly 4*(SETTLE_CYC+1)+1 cycles after the cycle in which start is accepted (13 cycles for the default).
REQ-023 SHALL ignore *_i in every state other than CHECK.

Reset
REQ-024 SHALL, while rst_n=0, hold state=IDLE and drive a_o=0, b_o=0, busy=0, done=0, pass=0, err_mask=0 and err_count=0, regardless of clock.
REQ-025 SHALL, on reset assertion mid-run, abandon the run with no done pulse and keep no partial results.
REQ-026 SHALL, after rst_n deasserts, accept a start on the first rising edge.

Structure
REQ-027 SHALL take the FSM state enum, the err_mask bit-index constants and NUM_VECTORS=4 from shared package gate_selftest_pkg.
REQ-028 SHALL instantiate one combinational sub-module, gate_expect, that maps (a,b) to the 7 expected bits in err_mask order.
REQ-029 SHALL register all outputs; no output SHALL combinationally depend on *_i.

Verification
REQ-030 SHALL be verified by a scenario in which a correct gate model is attached and start is pulsed: done occurs at cycle 13, pass=1, err_mask=0000000, err_count=0.
REQ-031 SHALL be verified by a scenario in which or_i is faulted to a&b: err_mask=0000010, err_count=2 (vectors 01 and 10), pass=0.
REQ-032 SHALL be verified by a scenario in which not_i is stuck at 0: err_mask=0000100, err_count=2 (vectors 00 and 01), pass=0.
REQ-033 SHALL be verified by a scenario in which start is held high for the whole run: exactly one run, one done pulse, and no restart in DONE.
REQ-034 SHALL be verified by a scenario in which rst_n is dropped during the vector-10 APPLY: all outputs are 0 immediately, no done pulse follows, and a fresh run then passes.
REQ-035 SHALL be verified by a scenario with SETTLE_CYC=1 and two back-to-back runs (faulty, then correct): done occurs at cycle 9 each time, and the second run reports pass=1, err_mask=0.
